// File: rtl/imm_enc.sv
// RISC-V instruction encoder: packs format/fields/immediate into a 32-bit word.
// Two-stage valid/ready pipeline; stage 1 checks encodability, stage 2 packs.
module imm_enc #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       i_type,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      immediate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instruction,
    output logic             err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [2:0] TypeI = 3'd0;
    localparam logic [2:0] TypeS = 3'd1;
    localparam logic [2:0] TypeB = 3'd2;
    localparam logic [2:0] TypeU = 3'd3;
    localparam logic [2:0] TypeJ = 3'd4;
    localparam logic [2:0] TypeR = 3'd5;

    logic             s1_valid_q;
    logic [2:0]       s1_type_q;
    logic [6:0]       s1_opcode_q;
    logic [4:0]       s1_rd_q;
    logic [4:0]       s1_rs1_q;
    logic [4:0]       s1_rs2_q;
    logic [2:0]       s1_funct3_q;
    logic [6:0]       s1_funct7_q;
    logic [31:0]      s1_imm_q;
    logic             s1_err_q;

    logic             s2_valid_q;
    logic [31:0]      s2_instr_q;
    logic             s2_err_q;

    logic [CNT_W-1:0] enc_count_q;
    logic [CNT_W-1:0] err_count_q;

    logic             accept;
    logic             handoff;
    logic             s2_load;
    logic             imm_err;
    logic [31:0]      pack;

    logic             sext12_ok;
    logic             sext13_ok;
    logic             sext21_ok;

    assign handoff  = s2_valid_q & out_ready;
    assign s2_load  = !s2_valid_q | out_ready;
    assign in_ready = !s1_valid_q | s2_load;
    assign accept   = in_valid & in_ready;

    // Upper bits must be a pure sign extension of the encodable field.
    assign sext12_ok = (&immediate[31:11]) | ~(|immediate[31:11]);
    assign sext13_ok = (&immediate[31:12]) | ~(|immediate[31:12]);
    assign sext21_ok = (&immediate[31:20]) | ~(|immediate[31:20]);

    always_comb begin
        imm_err = 1'b0;
        case (i_type)
            TypeI, TypeS: imm_err = !sext12_ok;
            TypeB:        imm_err = !sext13_ok | immediate[0];
            TypeU:        imm_err = |immediate[11:0];
            TypeJ:        imm_err = !sext21_ok | immediate[0];
            TypeR:        imm_err = 1'b0;
            default:      imm_err = 1'b1;
        endcase
    end

    always_comb begin
        pack = '0;
        case (s1_type_q)
            TypeI: pack = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            TypeS: pack = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_imm_q[4:0],
                           s1_opcode_q};
            TypeB: pack = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                           s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
            TypeU: pack = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
            TypeJ: pack = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12], s1_rd_q,
                           s1_opcode_q};
            TypeR: pack = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            default: pack = '0;
        endcase
        if (s1_err_q) begin
            pack = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_type_q   <= '0;
            s1_opcode_q <= '0;
            s1_rd_q     <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_funct3_q <= '0;
            s1_funct7_q <= '0;
            s1_imm_q    <= '0;
            s1_err_q    <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (accept) begin
                s1_type_q   <= i_type;
                s1_opcode_q <= opcode;
                s1_rd_q     <= rd;
                s1_rs1_q    <= rs1;
                s1_rs2_q    <= rs2;
                s1_funct3_q <= funct3;
                s1_funct7_q <= funct7;
                s1_imm_q    <= immediate;
                s1_err_q    <= imm_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_q <= pack;
                s2_err_q   <= s1_err_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count_q <= '0;
            err_count_q <= '0;
        end else if (handoff) begin
            enc_count_q <= enc_count_q + 1'b1;
            if (s2_err_q && (err_count_q != '1)) begin
                err_count_q <= err_count_q + 1'b1;
            end
        end
    end

    assign out_valid   = s2_valid_q;
    assign instruction = s2_instr_q;
    assign err         = s2_err_q;
    assign enc_count   = enc_count_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_imm_enc.sv
// Self-checking bench for imm_enc: directed vector table, stall sequence,
// random backpressure stream against a scoreboard, and mid-stream reset.
module tb_imm_enc;

    localparam int unsigned CW = 4;
    localparam int NV = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    i_type;
    logic [6:0]    opcode;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [31:0]   immediate;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   instruction;
    logic          err;
    logic [CW-1:0] enc_count;
    logic [CW-1:0] err_count;

    imm_enc #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .i_type     (i_type),
        .opcode     (opcode),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct3     (funct3),
        .funct7     (funct7),
        .immediate  (immediate),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instruction(instruction),
        .err        (err),
        .enc_count  (enc_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  t;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] ei;
        logic        ee;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    vec_t          vecs[NV];
    exp_t          exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_ho = 0;
    logic [CW-1:0] m_enc = '0;
    logic [CW-1:0] m_err = '0;
    bit            was_stalled = 0;
    logic [31:0]   held_instr;
    logic          held_err;
    bit            last_rdy;

    function automatic vec_t mk(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd_v,
                                input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm, input logic [31:0] ei, input logic ee);
        vec_t v;
        v.t = t; v.op = op; v.rd = rd_v; v.rs1 = rs1_v; v.rs2 = rs2_v;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.ei = ei; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic drive(input bit iv, input int vi);
        in_valid  = iv;
        i_type    = vecs[vi].t;
        opcode    = vecs[vi].op;
        rd        = vecs[vi].rd;
        rs1       = vecs[vi].rs1;
        rs2       = vecs[vi].rs2;
        funct3    = vecs[vi].f3;
        funct7    = vecs[vi].f7;
        immediate = vecs[vi].imm;
    endtask

    task automatic model_handoff(input logic e);
        m_enc = m_enc + 1'b1;
        if (e && m_err != '1) m_err = m_err + 1'b1;
    endtask

    // One request, empty pipeline, out_ready high: checks 2-cycle latency and result.
    task automatic single(input int vi);
        drive(1, vi);
        out_ready = 1;
        #1 chk($sformatf("v%0d_in_ready", vi), in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        #1 chk($sformatf("v%0d_lat1_valid", vi), out_valid, 0);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_lat2_valid", vi), out_valid, 1);
        chk($sformatf("v%0d_instr", vi), instruction, vecs[vi].ei);
        chk($sformatf("v%0d_err", vi), err, vecs[vi].ee);
        model_handoff(vecs[vi].ee);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_drained", vi), out_valid, 0);
        chk($sformatf("v%0d_enc_count", vi), enc_count, m_enc);
        chk($sformatf("v%0d_err_count", vi), err_count, m_err);
        @(negedge clk);
    endtask

    // One clock of streaming with the scoreboard; starts and ends on a falling edge.
    task automatic cycle(input bit iv, input int vi, input bit ordy, output bit acc);
        exp_t e;
        drive(iv, vi);
        out_ready = ordy;
        #1;
        chk("enc_count", enc_count, m_enc);
        chk("err_count", err_count, m_err);
        if (was_stalled) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_instr", instruction, held_instr);
            chk("hold_err", err, held_err);
        end
        was_stalled = out_valid & !out_ready;
        held_instr  = instruction;
        held_err    = err;
        last_rdy    = in_ready;
        acc = in_valid & in_ready;
        if (out_valid & out_ready) begin
            n_ho++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_output: got %h, want nothing (t=%0t)", instruction, $time);
                model_handoff(err);
            end else begin
                e = exp_q.pop_front();
                chk("stream_instr", instruction, e.instr);
                chk("stream_err", err, e.err);
                model_handoff(e.err);
            end
        end
        if (acc) begin
            e.instr = vecs[vi].ei;
            e.err   = vecs[vi].ee;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        in_valid = 0;
        out_ready = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        exp_q.delete();
        m_enc = '0;
        m_err = '0;
        was_stalled = 0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int sent;
        int cyc;
        int ho0;

        vecs[0]  = mk(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000000A, 32'h00A00093, 0);
        vecs[1]  = mk(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFFDFF0EF, 0);
        vecs[2]  = mk(3'd1, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'h00, 32'h00000008, 32'h0021A423, 0);
        vecs[3]  = mk(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 0);
        vecs[4]  = mk(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001, 32'h00000000, 1);
        vecs[5]  = mk(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 32'h00000000, 1);
        vecs[6]  = mk(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 32'h80000093, 0);
        vecs[7]  = mk(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000003, 32'h00000000, 1);
        vecs[8]  = mk(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00100000, 32'h00000000, 1);
        vecs[9]  = mk(3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'h00000000, 32'h00000000, 1);
        vecs[10] = mk(3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEADBEEF, 32'h002081B3, 0);
        vecs[11] = mk(3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h00000000, 32'h402081B3, 0);
        vecs[12] = mk(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFF8, 32'hFE208CE3, 0);
        vecs[13] = mk(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001000, 32'h00000000, 1);
        vecs[14] = mk(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000FFE, 32'h7E000FE3, 0);
        vecs[15] = mk(3'd1, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 32'hFE000FA3, 0);
        vecs[16] = mk(3'd4, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000002, 32'h0020006F, 0);
        vecs[17] = mk(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 32'h00000000, 1);
        vecs[18] = mk(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000007FF, 32'h7FF00093, 0);
        vecs[19] = mk(3'd4, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000FFFFE, 32'h7FFFF06F, 0);

        rst_n = 0;
        out_ready = 0;
        drive(0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_instruction", instruction, 0);
        chk("rst_err", err, 0);
        chk("rst_enc_count", enc_count, 0);
        chk("rst_err_count", err_count, 0);
        rst_n = 1;
        @(negedge clk);

        // Directed table, one request at a time.
        for (int i = 0; i < NV; i++) single(i);

        // Eight back-to-back requests against a 5-cycle stall.
        do_reset();
        sent = 0;
        cyc = 0;
        while ((sent < 8 || exp_q.size() > 0) && cyc < 200) begin
            cycle(sent < 8, sent, cyc >= 5, acc);
            if (acc) sent++;
            cyc++;
            if (cyc == 5) begin
                chk("stall_accepts", sent, 2);
                chk("stall_in_ready", last_rdy, 0);
            end
        end
        chk("stall_drained", exp_q.size(), 0);
        cycle(0, 0, 1, acc);
        chk("stall_enc_count_8", enc_count, 8);

        // Random valid/ready over 1000 requests.
        do_reset();
        sent = 0;
        cyc = 0;
        ho0 = n_ho;
        while ((sent < 1000 || exp_q.size() > 0) && cyc < 20000) begin
            int vi;
            bit iv;
            vi = $urandom_range(NV - 1);
            iv = (sent < 1000) && ($urandom_range(3) != 0);
            cycle(iv, vi, $urandom_range(1) == 1, acc);
            if (acc) sent++;
            cyc++;
        end
        chk("rand_handoffs", n_ho - ho0, 1000);

        // Fill the pipeline under stall, then reset between clock edges.
        cycle(1, 3, 0, acc);
        cycle(1, 5, 0, acc);
        cycle(1, 6, 0, acc);
        #2 rst_n = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_enc_count", enc_count, 0);
        chk("midrst_err_count", err_count, 0);
        chk("midrst_instruction", instruction, 0);
        in_valid = 0;
        exp_q.delete();
        m_enc = '0;
        m_err = '0;
        was_stalled = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        single(2);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, acc);
        chk("post_rst_enc_count", enc_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
